// File: rtl/alu_loader_pkg.sv
// Shared types for the ALU operand loader: FSM state encoding (mirrored on state_dbg),
// flag payload layout and the opcode map used by the ALU.
package alu_loader_pkg;

    localparam int unsigned OP_W_DEF = 3;
    localparam int unsigned FLG_W    = 4;
    localparam int unsigned ST_W     = 3;

    typedef enum logic [ST_W-1:0] {
        ST_LOAD_A   = 3'd0,
        ST_LOAD_B   = 3'd1,
        ST_LOAD_OP  = 3'd2,
        ST_ISSUE    = 3'd3,
        ST_WAIT_RES = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    // Flag payload as returned by the ALU, MSB first.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    localparam logic [OP_W_DEF-1:0] OP_PASS = 3'd0;
    localparam logic [OP_W_DEF-1:0] OP_ADD  = 3'd1;
    localparam logic [OP_W_DEF-1:0] OP_SUB  = 3'd2;
    localparam logic [OP_W_DEF-1:0] OP_AND  = 3'd3;
    localparam logic [OP_W_DEF-1:0] OP_OR   = 3'd4;
    localparam logic [OP_W_DEF-1:0] OP_XOR  = 3'd5;
    localparam logic [OP_W_DEF-1:0] OP_SHL  = 3'd6;
    localparam logic [OP_W_DEF-1:0] OP_SHR  = 3'd7;

endpackage

// File: rtl/alu_operand_loader_sync.sv
// Strobe synchronizer: SYNC_STAGES flops into clk, then a one-cycle pulse on each rising
// edge of the synchronized level. A held strobe produces a single pulse.
module strobe_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise_c
);

    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("strobe_sync_edge: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Pulse lands one cycle before the consumer's capture edge: pin-to-capture is SYNC_STAGES+1.
    assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Serial A/B/opcode loader feeding the ALU over valid/ready, then holding its result.
// Optional opcode range check is compiled in with ALU_LOADER_OPCHECK_EN.
module alu_operand_loader
    import alu_loader_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned OP_W        = OP_W_DEF,
    parameter int unsigned NUM_OPS     = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             strobe,
    input  logic             abort,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OP_W-1:0]  alu_op,
    output logic             alu_valid,
    input  logic             alu_ready,
    input  logic [WIDTH-1:0] res_in,
    input  logic [FLG_W-1:0] res_flg,
    input  logic             res_valid,
    output logic [WIDTH-1:0] res_out,
    output logic [FLG_W-1:0] flg_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [ST_W-1:0]  state_dbg
);

    if (NUM_OPS < 1 || NUM_OPS > (1 << OP_W) || OP_W > WIDTH) begin : g_bad_params
        $error("alu_operand_loader: NUM_OPS/OP_W/WIDTH out of range");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    flags_t           flg_q, flg_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             load_c;
    logic             op_legal_c;

    strobe_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (strobe),
        .rise_c   (load_c)
    );

`ifdef ALU_LOADER_OPCHECK_EN
    assign op_legal_c = (32'(din[OP_W-1:0]) < NUM_OPS);
`else
    assign op_legal_c = 1'b1;
`endif

    // Next state and register updates; abort overrides everything including a same-cycle event.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        flg_d   = flg_q;
        err_d   = err_q;

        if (abort) begin
            state_d = ST_LOAD_A;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD_A, ST_DONE: begin
                    if (load_c) begin
                        a_d     = din;
                        state_d = ST_LOAD_B;
                    end
                end
                ST_LOAD_B: begin
                    if (load_c) begin
                        b_d     = din;
                        state_d = ST_LOAD_OP;
                    end
                end
                ST_LOAD_OP: begin
                    if (load_c) begin
                        if (op_legal_c) begin
                            op_d    = din[OP_W-1:0];
                            err_d   = 1'b0;
                            state_d = ST_ISSUE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_LOAD_A;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (valid_q && alu_ready) begin
                        state_d = ST_WAIT_RES;
                    end
                end
                ST_WAIT_RES: begin
                    if (res_valid) begin
                        res_d   = res_in;
                        flg_d   = flags_t'(res_flg);
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_LOAD_A;
            endcase
        end

        // Status outputs are registered copies of the decoded next state.
        valid_d = (state_d == ST_ISSUE);
        busy_d  = (state_d == ST_ISSUE) || (state_d == ST_WAIT_RES);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            flg_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;
    assign alu_valid = valid_q;
    assign res_out   = res_q;
    assign flg_out   = flg_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader: operand table plus hand-written corner sequences.
module tb_alu_operand_loader;
    import alu_loader_pkg::*;

    localparam int unsigned SYNC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = '0;
    logic       strobe = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic       alu_valid;
    logic       alu_ready = 1'b0;
    logic [7:0] res_in = '0;
    logic [3:0] res_flg = '0;
    logic       res_valid = 1'b0;
    logic [7:0] res_out;
    logic [3:0] flg_out;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] state_dbg;

    int n_vec = 0;
    int n_miss = 0;

    alu_operand_loader #(
        .WIDTH       (8),
        .OP_W        (3),
        .NUM_OPS     (6),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .strobe    (strobe),
        .abort     (abort),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .res_in    (res_in),
        .res_flg   (res_flg),
        .res_valid (res_valid),
        .res_out   (res_out),
        .flg_out   (flg_out),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op_byte;
        logic [2:0] exp_op;
        logic [7:0] res;
        logic [3:0] flg;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Raise strobe and wait until the capture edge has passed.
    task automatic ev_begin(input logic [7:0] d);
        din    = d;
        strobe = 1'b1;
        repeat (SYNC + 1) tick();
    endtask

    task automatic ev_end();
        strobe = 1'b0;
        repeat (SYNC + 1) tick();
    endtask

    task automatic ev(input logic [7:0] d);
        ev_begin(d);
        ev_end();
    endtask

    task automatic pulse_result(input logic [7:0] r, input logic [3:0] f);
        res_in    = r;
        res_flg   = f;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{a: 8'h12, b: 8'h34, op_byte: 8'h01, exp_op: OP_ADD,  res: 8'h46, flg: 4'h0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, op_byte: 8'hFA, exp_op: OP_SUB,  res: 8'hFE, flg: 4'h8};
        vecs[2] = '{a: 8'h0F, b: 8'hF0, op_byte: 8'h03, exp_op: OP_AND,  res: 8'h00, flg: 4'h4};
        vecs[3] = '{a: 8'h00, b: 8'h5A, op_byte: 8'h04, exp_op: OP_OR,   res: 8'h5A, flg: 4'h0};
        vecs[4] = '{a: 8'hC3, b: 8'h3C, op_byte: 8'hF8, exp_op: OP_PASS, res: 8'hC3, flg: 4'h2};

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_state", 32'(state_dbg), 32'(ST_LOAD_A));
        chk("rst_valid", 32'(alu_valid), 32'h0);
        chk("rst_a",     32'(alu_a),     32'h0);
        chk("rst_b",     32'(alu_b),     32'h0);
        chk("rst_op",    32'(alu_op),    32'h0);
        chk("rst_res",   32'(res_out),   32'h0);
        chk("rst_flg",   32'(flg_out),   32'h0);
        chk("rst_busy",  32'(busy),      32'h0);
        chk("rst_done",  32'(done),      32'h0);
        chk("rst_err",   32'(err),       32'h0);

        // Ready already high: valid lasts exactly one cycle
        alu_ready = 1'b1;
        ev(8'h12);
        ev(8'h34);
        ev_begin(8'h01);
        chk("rdy_state_issue", 32'(state_dbg), 32'(ST_ISSUE));
        chk("rdy_valid",       32'(alu_valid), 32'h1);
        chk("rdy_a",           32'(alu_a),     32'h12);
        chk("rdy_b",           32'(alu_b),     32'h34);
        chk("rdy_op",          32'(alu_op),    32'h1);
        tick();
        chk("rdy_valid_drop",  32'(alu_valid), 32'h0);
        chk("rdy_state_wait",  32'(state_dbg), 32'(ST_WAIT_RES));
        alu_ready = 1'b0;
        ev_end();
        pulse_result(8'h46, 4'h0);
        chk("rdy_res",  32'(res_out), 32'h46);
        chk("rdy_done", 32'(done),    32'h1);

        // Operand table: each entry is a full load/issue/result round starting from DONE
        for (int i = 0; i < 5; i++) begin
            ev(vecs[i].a);
            chk("vec_state_b", 32'(state_dbg), 32'(ST_LOAD_B));
            ev(vecs[i].b);
            ev_begin(vecs[i].op_byte);
            chk("vec_valid",   32'(alu_valid), 32'h1);
            chk("vec_a",       32'(alu_a),     32'(vecs[i].a));
            chk("vec_b",       32'(alu_b),     32'(vecs[i].b));
            chk("vec_op",      32'(alu_op),    32'(vecs[i].exp_op));
            chk("vec_busy",    32'(busy),      32'h1);
            ev_end();
            chk("vec_valid_hold", 32'(alu_valid), 32'h1);
            alu_ready = 1'b1;
            tick();
            alu_ready = 1'b0;
            chk("vec_state_wait", 32'(state_dbg), 32'(ST_WAIT_RES));
            chk("vec_valid_low",  32'(alu_valid), 32'h0);
            pulse_result(vecs[i].res, vecs[i].flg);
            chk("vec_res",   32'(res_out),   32'(vecs[i].res));
            chk("vec_flg",   32'(flg_out),   32'(vecs[i].flg));
            chk("vec_done",  32'(done),      32'h1);
            chk("vec_state", 32'(state_dbg), 32'(ST_DONE));
        end

        // ISSUE stalled by ready low for 10 cycles
        ev(8'h21);
        ev(8'h43);
        ev(8'(OP_XOR));
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_valid", 32'(alu_valid), 32'h1);
            chk("stall_a",     32'(alu_a),     32'h21);
            chk("stall_op",    32'(alu_op),    32'(OP_XOR));
        end
        alu_ready = 1'b1;
        tick();
        alu_ready = 1'b0;
        chk("stall_release", 32'(state_dbg), 32'(ST_WAIT_RES));

        // Events while waiting for the result are dropped
        ev(8'h99);
        chk("wait_drop_state", 32'(state_dbg), 32'(ST_WAIT_RES));
        chk("wait_drop_a",     32'(alu_a),     32'h21);

        // Abort in WAIT_RES keeps the previous result
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_state", 32'(state_dbg), 32'(ST_LOAD_A));
        chk("abort_res",   32'(res_out),   32'hC3);
        chk("abort_valid", 32'(alu_valid), 32'h0);
        chk("abort_busy",  32'(busy),      32'h0);

        // Abort coincident with a load event: event lost
        din    = 8'h55;
        strobe = 1'b1;
        repeat (SYNC) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_ev_state", 32'(state_dbg), 32'(ST_LOAD_A));
        repeat (5) tick();
        chk("abort_ev_state2", 32'(state_dbg), 32'(ST_LOAD_A));
        chk("abort_ev_a",      32'(alu_a),     32'h21);
        ev_end();

        // Strobe held 20 cycles: one capture, SYNC+1 clocks after the rise
        din    = 8'h6C;
        strobe = 1'b1;
        repeat (SYNC) tick();
        chk("held_early", 32'(state_dbg), 32'(ST_LOAD_A));
        tick();
        chk("held_capture", 32'(state_dbg), 32'(ST_LOAD_B));
        chk("held_a",       32'(alu_a),     32'h6C);
        repeat (17) tick();
        chk("held_single", 32'(state_dbg), 32'(ST_LOAD_B));
        ev_end();

        // Result pulse and ready outside their states are ignored
        pulse_result(8'h77, 4'hF);
        chk("stray_res", 32'(res_out), 32'hC3);
        chk("stray_flg", 32'(flg_out), 32'h2);
        alu_ready = 1'b1;
        tick();
        alu_ready = 1'b0;
        chk("stray_ready", 32'(state_dbg), 32'(ST_LOAD_B));

        // Reset in the middle of a handshake
        ev(8'h01);
        ev_begin(8'(OP_ADD));
        chk("rst_hs_pre", 32'(alu_valid), 32'h1);
        alu_ready = 1'b1;
        rst       = 1'b1;
        tick();
        chk("rst_hs_valid", 32'(alu_valid), 32'h0);
        chk("rst_hs_state", 32'(state_dbg), 32'(ST_LOAD_A));
        chk("rst_hs_res",   32'(res_out),   32'h0);
        rst       = 1'b0;
        alu_ready = 1'b0;
        ev_end();

`ifdef ALU_LOADER_OPCHECK_EN
        // Opcodes >= 6 rejected, err sticky until next issue
        ev(8'h10);
        ev(8'h20);
        ev_begin(8'(OP_SHR));
        chk("opchk_state", 32'(state_dbg), 32'(ST_LOAD_A));
        chk("opchk_err",   32'(err),       32'h1);
        chk("opchk_valid", 32'(alu_valid), 32'h0);
        ev_end();
        chk("opchk_valid2", 32'(alu_valid), 32'h0);
        ev(8'h11);
        ev(8'h22);
        ev_begin(8'(OP_SHL));
        chk("opchk6_state", 32'(state_dbg), 32'(ST_LOAD_A));
        chk("opchk6_err",   32'(err),       32'h1);
        ev_end();
        ev(8'h11);
        ev(8'h22);
        chk("opchk_err_sticky", 32'(err), 32'h1);
        ev_begin(8'(OP_SUB));
        chk("opchk_issue", 32'(state_dbg), 32'(ST_ISSUE));
        chk("opchk_clear", 32'(err),       32'h0);
        chk("opchk_op",    32'(alu_op),    32'(OP_SUB));
        ev_end();
`else
        // Without the check every opcode is forwarded
        ev(8'h10);
        ev(8'h20);
        ev_begin(8'(OP_SHR));
        chk("noop_state", 32'(state_dbg), 32'(ST_ISSUE));
        chk("noop_op",    32'(alu_op),    32'(OP_SHR));
        chk("noop_err",   32'(err),       32'h0);
        ev_end();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        ev(8'h11);
        ev(8'h22);
        ev_begin(8'(OP_SHL));
        chk("noop6_state", 32'(state_dbg), 32'(ST_ISSUE));
        chk("noop6_op",    32'(alu_op),    32'(OP_SHL));
        chk("noop6_err",   32'(err),       32'h0);
        ev_end();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
